// File: rtl/tx_escape_arbiter_if.sv
// Byte handshake bundle between the TAP requesters, the TX escape arbiter and UART-TX.
interface tx_escape_arbiter_if;
    logic       DATA_VALID_I;
    logic [7:0] DATA_I;
    logic       DATA_READY_O;
    logic       CMD_VALID_I;
    logic [7:0] CMD_I;
    logic       CMD_READY_O;
    logic       CMD_ERR_O;
    logic       TX_FULL_I;
    logic       WRITE_O;
    logic [7:0] DATA_SEND_O;
    logic       BUSY_O;

    modport slave (
        input  DATA_VALID_I, DATA_I, CMD_VALID_I, CMD_I, TX_FULL_I,
        output DATA_READY_O, CMD_READY_O, CMD_ERR_O, WRITE_O, DATA_SEND_O, BUSY_O
    );

    modport master (
        output DATA_VALID_I, DATA_I, CMD_VALID_I, CMD_I, TX_FULL_I,
        input  DATA_READY_O, CMD_READY_O, CMD_ERR_O, WRITE_O, DATA_SEND_O, BUSY_O
    );
endinterface

// File: rtl/tx_escape_arbiter.sv
// Arbitrates TAP data/command bytes onto UART-TX with ESC doubling (data) and ESC prefix (cmd).
// Define TX_ESCAPE_ARBITER_CMD_PRIO_EN for strict command priority instead of round-robin.
module tx_escape_arbiter #(
    parameter logic [7:0] ESC = 8'hB1
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    tx_escape_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {st_idle, st_send_esc, st_send_byte} state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_q;
    logic [7:0] sel_byte;
    logic       grant_cmd;
    logic       accept;
    logic       data_rdy, cmd_rdy, cmd_err, wr;
    logic [7:0] send;

`ifdef TX_ESCAPE_ARBITER_CMD_PRIO_EN
    assign grant_cmd = bus.CMD_VALID_I;
`else
    logic last_cmd_q;   // last_grant: 0 = DATA, 1 = CMD
    assign grant_cmd = bus.CMD_VALID_I && (!bus.DATA_VALID_I || !last_cmd_q);
`endif

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        sel_byte = 8'h00;
        data_rdy = 1'b0;
        cmd_rdy  = 1'b0;
        cmd_err  = 1'b0;
        wr       = 1'b0;
        send     = 8'h00;
        case (state_q)
            st_idle: begin
                if (bus.CMD_VALID_I || bus.DATA_VALID_I) begin
                    accept = 1'b1;
                    if (grant_cmd) begin
                        cmd_rdy  = 1'b1;
                        sel_byte = bus.CMD_I;
                        // ESC is not a legal command: consume and flag it, write nothing
                        if (bus.CMD_I == ESC) cmd_err = 1'b1;
                        else                  state_d = st_send_esc;
                    end else begin
                        data_rdy = 1'b1;
                        sel_byte = bus.DATA_I;
                        state_d  = (bus.DATA_I == ESC) ? st_send_esc : st_send_byte;
                    end
                end
            end
            st_send_esc: begin
                send = ESC;
                wr   = !bus.TX_FULL_I;
                if (wr) state_d = st_send_byte;
            end
            st_send_byte: begin
                send = byte_q;
                wr   = !bus.TX_FULL_I;
                if (wr) state_d = st_idle;
            end
            default: state_d = st_idle;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= st_idle;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (accept) byte_q <= sel_byte;
        end
    end

`ifndef TX_ESCAPE_ARBITER_CMD_PRIO_EN
    always_ff @(posedge CLK_I) begin
        if (RST_I)       last_cmd_q <= 1'b0;
        else if (accept) last_cmd_q <= grant_cmd;
    end
`endif

    // Outputs are held low while reset is asserted, regardless of state or requests
    assign bus.DATA_READY_O = data_rdy && !RST_I;
    assign bus.CMD_READY_O  = cmd_rdy  && !RST_I;
    assign bus.CMD_ERR_O    = cmd_err  && !RST_I;
    assign bus.WRITE_O      = wr       && !RST_I;
    assign bus.DATA_SEND_O  = RST_I ? 8'h00 : send;
    assign bus.BUSY_O       = (state_q != st_idle) && !RST_I;
endmodule
